rename_reg_file: RTL and testbench
==================================

RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 SHALL provide parameter REG_NUM, default 32, architectural register count; REG_W, default 5, register index width.
REQ-002 SHALL provide parameter DATA_W, default 32, data width; ROB_W, default 4, ROB tag width (tag 0 = none).
REQ-003 SHALL provide parameter RD_PORTS, default 2, read port count; CKPT_NUM, default 4, checkpoint slots; CKPT_W, default 2, slot index width.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset
- ena  in  1  state-update enable
- in_rollback  in  1  full flush
- rd_idx  in  RD_PORTS*REG_W  read indices, port p at [p*REG_W +: REG_W]
- rd_value  out  RD_PORTS*DATA_W  read data
- rd_tag  out  RD_PORTS*ROB_W  producer tags
- rd_busy  out  RD_PORTS  pending-producer flags
- in_assign_ena  in  1  rename request
- in_assign_reg  in  REG_W  destination register
- in_assign_tag  in  ROB_W  producer tag
- in_commit_ena  in  1  commit request
- in_commit_reg  in  REG_W  committed register
- in_commit_tag  in  ROB_W  committing tag
- in_commit_value  in  DATA_W  committed data
- in_ckpt_save  in  1  take checkpoint
- out_ckpt_id  out  CKPT_W  slot the next save uses
- out_ckpt_full  out  1  no free slot
- in_ckpt_restore  in  1  restore checkpoint
- in_ckpt_restore_id  in  CKPT_W  slot to restore
- in_ckpt_release  in  1  free checkpoint
- in_ckpt_release_id  in  CKPT_W  slot to free
REQ-005 SHALL use one clock clk; rst is synchronous, active-high.

Function
REQ-006 SHALL hold per register: data, tag, busy; per slot: valid, snapshot of all tags and busy bits.
REQ-007 SHALL make register 0 read data 0, tag 0, busy 0 always; commits and assigns to register 0 are ignored.
REQ-008 SHALL drive read outputs combinationally from current state, regardless of ena.
REQ-009 SHALL update no state when ena is low, except under rst.
REQ-010 SHALL, on commit, write in_commit_value to data; if busy and tag equals in_commit_tag, clear busy and set tag 0.
REQ-011 SHALL apply the same tag-match clear to every valid snapshot in the commit cycle.
REQ-012 SHALL, on assign, set tag to in_assign_tag and busy 1; assign wins over commit clear on the same register; the committed data is still written.
REQ-013 SHALL drive out_ckpt_id as the lowest-indexed free slot and out_ckpt_full when all slots are valid.
REQ-014 SHALL, on save when not full, mark slot out_ckpt_id valid and capture the next-state tags/busy, including same-cycle commit and assign; save when full is ignored.
REQ-015 SHALL, on restore of a valid slot, load live tags/busy from that snapshot with same-cycle commit clear applied, then free that slot; data is never restored.
REQ-016 SHALL ignore assign and save in a restore cycle; restore of an invalid slot is a no-op; commit and release still apply.
REQ-017 SHALL, on release, free the slot; save may reuse a slot released in the same cycle only from the next cycle.
REQ-018 SHALL apply in_rollback as: all tags 0, busy 0, all slots free; data keeps its value plus any same-cycle commit.
REQ-019 SHALL apply priority rst > in_rollback > restore > {commit, assign, save, release}.

Reset
REQ-020 SHALL on rst clear all data, tags, busy and slot valid bits, giving rd_* = 0, out_ckpt_id = 0, out_ckpt_full = 0 next cycle; rst mid-operation discards all pending state.

Configuration
REQ-021 SHALL, with RENAME_RF_BYPASS_EN defined, forward a same-cycle commit (ena, in_commit_ena, nonzero reg matching rd_idx): rd_value = in_commit_value; on tag match rd_busy = 0, rd_tag = 0.
REQ-022 SHALL, without RENAME_RF_BYPASS_EN, show commit effects on reads only from the following cycle.

Verification
REQ-023 SHALL cover: assign r5 tag 3, commit r5 tag 3 value 0x1234 -> r5 reads data 0x1234, busy 0, tag 0.
REQ-024 SHALL cover: assign r5 tag 3, assign r5 tag 7, commit r5 tag 3 value 9 -> data 9, busy 1, tag 7.
REQ-025 SHALL cover: assign r2 tag 1, save (slot 0), assign r2 tag 4, commit r2 tag 1, restore slot 0 -> r2 busy 0, tag 0; slot 0 free.
REQ-026 SHALL cover: four saves -> ids 0,1,2,3, out_ckpt_full 1; fifth save ignored; release 2 -> out_ckpt_id 2 next cycle.
REQ-027 SHALL cover: busy r1..r31 plus in_rollback with commit r4 value 0xAA -> all busy 0, all slots free, r4 data 0xAA.
REQ-028 SHALL cover: read r6 while committing r6 value 0x55 matching tag -> 0x55 same cycle with RENAME_RF_BYPASS_EN, old data without.

Source files
------------

// File: rtl/rename_reg_file.sv
// -----------------------------------------------------------------------------
// rename_reg_file
//
// Architectural register file with rename state for an out-of-order core.
// Each register holds committed data plus the ROB tag of its pending producer
// and a busy flag. A small pool of checkpoint slots snapshots all tags/busy
// bits so that a branch mispredict can restore the rename map.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ena                   state-update enable (reads are live regardless)
//   in_rollback           full flush: all tags/busy cleared, all slots freed
//   rd_idx                RD_PORTS packed read indices
//   rd_value/rd_tag/rd_busy  per-port read data, producer tag, busy flag
//   in_assign_*           rename a destination register to a new producer tag
//   in_commit_*           write back committed data, retire matching producer
//   in_ckpt_save          snapshot rename state into slot out_ckpt_id
//   out_ckpt_id           lowest free slot (next save target)
//   out_ckpt_full         all slots in use
//   in_ckpt_restore(_id)  reload rename state from a slot and free it
//   in_ckpt_release(_id)  free a slot without restoring it
//
// Configuration
//   RENAME_RF_BYPASS_EN   when defined, a same-cycle commit is forwarded to
//                         matching read ports; otherwise reads see commits
//                         from the following cycle.
// -----------------------------------------------------------------------------
module rename_reg_file #(
    parameter int REG_NUM  = 32,
    parameter int REG_W    = 5,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 4,
    parameter int RD_PORTS = 2,
    parameter int CKPT_NUM = 4,
    parameter int CKPT_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         in_rollback,
    input  logic [RD_PORTS*REG_W-1:0]    rd_idx,
    output logic [RD_PORTS*DATA_W-1:0]   rd_value,
    output logic [RD_PORTS*ROB_W-1:0]    rd_tag,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         in_assign_ena,
    input  logic [REG_W-1:0]             in_assign_reg,
    input  logic [ROB_W-1:0]             in_assign_tag,
    input  logic                         in_commit_ena,
    input  logic [REG_W-1:0]             in_commit_reg,
    input  logic [ROB_W-1:0]             in_commit_tag,
    input  logic [DATA_W-1:0]            in_commit_value,
    input  logic                         in_ckpt_save,
    output logic [CKPT_W-1:0]            out_ckpt_id,
    output logic                         out_ckpt_full,
    input  logic                         in_ckpt_restore,
    input  logic [CKPT_W-1:0]            in_ckpt_restore_id,
    input  logic                         in_ckpt_release,
    input  logic [CKPT_W-1:0]            in_ckpt_release_id
);

    // Live state
    logic [DATA_W-1:0]   data_q     [REG_NUM];
    logic [ROB_W-1:0]    tag_q      [REG_NUM];
    logic [REG_NUM-1:0]  busy_q;
    logic [CKPT_NUM-1:0] ckpt_valid_q;
    logic [ROB_W-1:0]    snap_tag_q [CKPT_NUM][REG_NUM];
    logic [REG_NUM-1:0]  snap_busy_q[CKPT_NUM];

    // Next state
    logic [DATA_W-1:0]   data_d     [REG_NUM];
    logic [ROB_W-1:0]    tag_d      [REG_NUM];
    logic [REG_NUM-1:0]  busy_d;
    logic [CKPT_NUM-1:0] ckpt_valid_d;
    logic [ROB_W-1:0]    snap_tag_d [CKPT_NUM][REG_NUM];
    logic [REG_NUM-1:0]  snap_busy_d[CKPT_NUM];

    logic commit_hit;
    logic assign_hit;
    logic restore_cycle;
    logic restore_hit;
    logic [CKPT_W-1:0] free_id;
    logic              all_full;

    // Register 0 is hardwired, so requests naming it are dropped here.
    assign commit_hit    = ena && in_commit_ena && (in_commit_reg != '0);
    assign assign_hit    = ena && in_assign_ena && (in_assign_reg != '0);
    assign restore_cycle = ena && in_ckpt_restore;
    assign restore_hit   = restore_cycle && ckpt_valid_q[in_ckpt_restore_id];

    // Lowest-indexed free slot; scanning downward leaves the lowest one last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        free_id  = '0;
        all_full = 1'b1;
        for (int i = CKPT_NUM - 1; i >= 0; i--) begin
            if (!ckpt_valid_q[i]) begin
                free_id  = CKPT_W'(i);
                all_full = 1'b0;
            end
        end
    end

    assign out_ckpt_id   = free_id;
    assign out_ckpt_full = all_full;

    // Next-state computation. Later statements intentionally override earlier
    // ones, which encodes the priority rollback > restore > assign > commit.
    always_comb begin
        // NOTE: blocking assignments here build the next state step by step;
        // only the registering block below uses non-blocking assignments.
        data_d       = data_q;
        tag_d        = tag_q;
        busy_d       = busy_q;
        ckpt_valid_d = ckpt_valid_q;
        snap_tag_d   = snap_tag_q;
        snap_busy_d  = snap_busy_q;

        // Committed data always lands, even under rollback or restore.
        if (commit_hit) begin
            data_d[in_commit_reg] = in_commit_value;
        end

        if (ena && in_rollback) begin
            for (int i = 0; i < REG_NUM; i++) begin
                tag_d[i] = '0;
            end
            busy_d       = '0;
            ckpt_valid_d = '0;
        end else if (ena) begin
            if (commit_hit) begin
                if (busy_q[in_commit_reg] && tag_q[in_commit_reg] == in_commit_tag) begin
                    busy_d[in_commit_reg] = 1'b0;
                    tag_d[in_commit_reg]  = '0;
                end
                // A producer retiring now must not reappear after a restore.
                for (int c = 0; c < CKPT_NUM; c++) begin
                    if (ckpt_valid_q[c] && snap_busy_q[c][in_commit_reg] &&
                        snap_tag_q[c][in_commit_reg] == in_commit_tag) begin
                        snap_busy_d[c][in_commit_reg] = 1'b0;
                        snap_tag_d[c][in_commit_reg]  = '0;
                    end
                end
            end

            if (restore_hit) begin
                tag_d  = snap_tag_d[in_ckpt_restore_id];
                busy_d = snap_busy_d[in_ckpt_restore_id];
                ckpt_valid_d[in_ckpt_restore_id] = 1'b0;
            end else if (!restore_cycle && assign_hit) begin
                tag_d[in_assign_reg]  = in_assign_tag;
                busy_d[in_assign_reg] = 1'b1;
            end

            if (in_ckpt_release) begin
                ckpt_valid_d[in_ckpt_release_id] = 1'b0;
            end

            // free_id comes from the current valid bits, so a slot released
            // this cycle is not a save target until the next one.
            if (!restore_cycle && in_ckpt_save && !all_full) begin
                ckpt_valid_d[free_id] = 1'b1;
                snap_tag_d[free_id]   = tag_d;
                snap_busy_d[free_id]  = busy_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register arrays are cleared on reset because software
            // may read any register right after reset and expect zero.
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q       <= '0;
            ckpt_valid_q <= '0;
            for (int c = 0; c < CKPT_NUM; c++) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    snap_tag_q[c][i] <= '0;
                end
                snap_busy_q[c] <= '0;
            end
        end else begin
            data_q       <= data_d;
            tag_q        <= tag_d;
            busy_q       <= busy_d;
            ckpt_valid_q <= ckpt_valid_d;
            snap_tag_q   <= snap_tag_d;
            snap_busy_q  <= snap_busy_d;
        end
    end

    // Read ports
    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [REG_W-1:0]  idx;
        logic [DATA_W-1:0] val;
        logic [ROB_W-1:0]  tg;
        logic              bz;

        assign idx = rd_idx[p*REG_W +: REG_W];

        always_comb begin
            val = data_q[idx];
            tg  = tag_q[idx];
            bz  = busy_q[idx];
`ifdef RENAME_RF_BYPASS_EN
            if (commit_hit && in_commit_reg == idx) begin
                val = in_commit_value;
                if (bz && tg == in_commit_tag) begin
                    bz = 1'b0;
                    tg = '0;
                end
            end
`endif
            if (idx == '0) begin
                val = '0;
                tg  = '0;
                bz  = 1'b0;
            end
        end

        assign rd_value[p*DATA_W +: DATA_W] = val;
        assign rd_tag[p*ROB_W +: ROB_W]     = tg;
        assign rd_busy[p]                   = bz;
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// -----------------------------------------------------------------------------
// tb_rename_reg_file
//
// Self-checking bench for rename_reg_file: a table of single-cycle register
// operations with hand-derived expectations, hand-written checkpoint and
// rollback sequences, and a randomized run compared against a rule-level
// reference model. Works with or without RENAME_RF_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_rename_reg_file;

    localparam int REG_NUM  = 32;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int ROB_W    = 4;
    localparam int RD_PORTS = 2;
    localparam int CKPT_NUM = 4;
    localparam int CKPT_W   = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       ena;
    logic                       in_rollback;
    logic [RD_PORTS*REG_W-1:0]  rd_idx;
    logic [RD_PORTS*DATA_W-1:0] rd_value;
    logic [RD_PORTS*ROB_W-1:0]  rd_tag;
    logic [RD_PORTS-1:0]        rd_busy;
    logic                       in_assign_ena;
    logic [REG_W-1:0]           in_assign_reg;
    logic [ROB_W-1:0]           in_assign_tag;
    logic                       in_commit_ena;
    logic [REG_W-1:0]           in_commit_reg;
    logic [ROB_W-1:0]           in_commit_tag;
    logic [DATA_W-1:0]          in_commit_value;
    logic                       in_ckpt_save;
    logic [CKPT_W-1:0]          out_ckpt_id;
    logic                       out_ckpt_full;
    logic                       in_ckpt_restore;
    logic [CKPT_W-1:0]          in_ckpt_restore_id;
    logic                       in_ckpt_release;
    logic [CKPT_W-1:0]          in_ckpt_release_id;

    rename_reg_file dut (
        .clk                (clk),
        .rst                (rst),
        .ena                (ena),
        .in_rollback        (in_rollback),
        .rd_idx             (rd_idx),
        .rd_value           (rd_value),
        .rd_tag             (rd_tag),
        .rd_busy            (rd_busy),
        .in_assign_ena      (in_assign_ena),
        .in_assign_reg      (in_assign_reg),
        .in_assign_tag      (in_assign_tag),
        .in_commit_ena      (in_commit_ena),
        .in_commit_reg      (in_commit_reg),
        .in_commit_tag      (in_commit_tag),
        .in_commit_value    (in_commit_value),
        .in_ckpt_save       (in_ckpt_save),
        .out_ckpt_id        (out_ckpt_id),
        .out_ckpt_full      (out_ckpt_full),
        .in_ckpt_restore    (in_ckpt_restore),
        .in_ckpt_restore_id (in_ckpt_restore_id),
        .in_ckpt_release    (in_ckpt_release),
        .in_ckpt_release_id (in_ckpt_release_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_data [REG_NUM];
    logic [ROB_W-1:0]  m_tag  [REG_NUM];
    bit                m_busy [REG_NUM];
    bit                s_valid[CKPT_NUM];
    logic [ROB_W-1:0]  s_tag  [CKPT_NUM][REG_NUM];
    bit                s_busy [CKPT_NUM][REG_NUM];

    function automatic int model_free_slot();
        for (int s = 0; s < CKPT_NUM; s++) if (!s_valid[s]) return s;
        return -1;
    endfunction

    // Applies one clock edge worth of the documented rules to the model,
    // using the inputs currently driven.
    task automatic model_step();
        int  slot;
        bit  cm;
        slot = model_free_slot();
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                m_data[r] = '0; m_tag[r] = '0; m_busy[r] = 0;
            end
            for (int s = 0; s < CKPT_NUM; s++) s_valid[s] = 0;
            return;
        end
        if (!ena) return;
        cm = in_commit_ena && in_commit_reg != 0;
        if (cm) m_data[in_commit_reg] = in_commit_value;
        if (in_rollback) begin
            for (int r = 0; r < REG_NUM; r++) begin
                m_tag[r] = '0; m_busy[r] = 0;
            end
            for (int s = 0; s < CKPT_NUM; s++) s_valid[s] = 0;
            return;
        end
        if (cm) begin
            if (m_busy[in_commit_reg] && m_tag[in_commit_reg] == in_commit_tag) begin
                m_busy[in_commit_reg] = 0; m_tag[in_commit_reg] = '0;
            end
            for (int s = 0; s < CKPT_NUM; s++)
                if (s_valid[s] && s_busy[s][in_commit_reg] && s_tag[s][in_commit_reg] == in_commit_tag) begin
                    s_busy[s][in_commit_reg] = 0; s_tag[s][in_commit_reg] = '0;
                end
        end
        if (in_ckpt_restore) begin
            if (s_valid[in_ckpt_restore_id]) begin
                for (int r = 0; r < REG_NUM; r++) begin
                    m_tag[r]  = s_tag[in_ckpt_restore_id][r];
                    m_busy[r] = s_busy[in_ckpt_restore_id][r];
                end
                s_valid[in_ckpt_restore_id] = 0;
            end
        end else if (in_assign_ena && in_assign_reg != 0) begin
            m_tag[in_assign_reg] = in_assign_tag; m_busy[in_assign_reg] = 1;
        end
        if (in_ckpt_release) s_valid[in_ckpt_release_id] = 0;
        if (!in_ckpt_restore && in_ckpt_save && slot >= 0) begin
            s_valid[slot] = 1;
            for (int r = 0; r < REG_NUM; r++) begin
                s_tag[slot][r] = m_tag[r]; s_busy[slot][r] = m_busy[r];
            end
        end
    endtask

    function automatic logic [63:0] pack(input logic [DATA_W-1:0] v, input logic [ROB_W-1:0] t, input logic b);
        return {27'd0, v, t, b};
    endfunction

    function automatic logic [63:0] model_read(input int r);
        logic [DATA_W-1:0] v;
        logic [ROB_W-1:0]  t;
        logic              b;
        if (r == 0) return '0;
        v = m_data[r]; t = m_tag[r]; b = m_busy[r];
`ifdef RENAME_RF_BYPASS_EN
        if (ena && in_commit_ena && in_commit_reg == r) begin
            v = in_commit_value;
            if (b && t == in_commit_tag) begin b = 0; t = '0; end
        end
`endif
        return pack(v, t, b);
    endfunction

    function automatic logic [63:0] port_out(input int p);
        return pack(rd_value[p*DATA_W +: DATA_W], rd_tag[p*ROB_W +: ROB_W], rd_busy[p]);
    endfunction

    task automatic set_rd(input int p, input int r);
        rd_idx[p*REG_W +: REG_W] = REG_W'(r);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        ena = 1; in_rollback = 0;
        in_assign_ena = 0; in_assign_reg = '0; in_assign_tag = '0;
        in_commit_ena = 0; in_commit_reg = '0; in_commit_tag = '0; in_commit_value = '0;
        in_ckpt_save = 0; in_ckpt_restore = 0; in_ckpt_restore_id = '0;
        in_ckpt_release = 0; in_ckpt_release_id = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic do_assign(input int r, input int t);
        idle(); in_assign_ena = 1; in_assign_reg = REG_W'(r); in_assign_tag = ROB_W'(t);
        tick(); idle();
    endtask

    task automatic read_check(input string name, input int r, input logic [63:0] exp);
        set_rd(0, r);
        #1;
        check(name, port_out(0), exp);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string             name;
        logic              en;
        logic              a_en;
        logic [REG_W-1:0]  a_reg;
        logic [ROB_W-1:0]  a_tag;
        logic              c_en;
        logic [REG_W-1:0]  c_reg;
        logic [ROB_W-1:0]  c_tag;
        logic [DATA_W-1:0] c_val;
        logic [REG_W-1:0]  chk;
        logic [DATA_W-1:0] e_val;
        logic [ROB_W-1:0]  e_tag;
        logic              e_busy;
    } vec_t;

    vec_t vecs[13];

    initial begin
        rst = 1;
        rd_idx = '0;
        idle();

        vecs[0]  = '{"assign_r5_t3",        1, 1, 5, 3, 0, 0, 0, 32'h0,    5, 32'h0,    3, 1};
        vecs[1]  = '{"commit_r5_t3",        1, 0, 0, 0, 1, 5, 3, 32'h1234, 5, 32'h1234, 0, 0};
        vecs[2]  = '{"reassign_r5_t3",      1, 1, 5, 3, 0, 0, 0, 32'h0,    5, 32'h1234, 3, 1};
        vecs[3]  = '{"assign_r5_t7",        1, 1, 5, 7, 0, 0, 0, 32'h0,    5, 32'h1234, 7, 1};
        vecs[4]  = '{"stale_commit_r5_t3",  1, 0, 0, 0, 1, 5, 3, 32'h9,    5, 32'h9,    7, 1};
        vecs[5]  = '{"assign_r0_ignored",   1, 1, 0, 2, 0, 0, 0, 32'h0,    0, 32'h0,    0, 0};
        vecs[6]  = '{"commit_r0_ignored",   1, 0, 0, 0, 1, 0, 1, 32'h77,   0, 32'h0,    0, 0};
        vecs[7]  = '{"ena_low_no_update",   0, 1, 7, 5, 1, 7, 0, 32'h99,   7, 32'h0,    0, 0};
        vecs[8]  = '{"assign_r7_t5",        1, 1, 7, 5, 0, 0, 0, 32'h0,    7, 32'h0,    5, 1};
        vecs[9]  = '{"assign_beats_clear",  1, 1, 7, 6, 1, 7, 5, 32'h42,   7, 32'h42,   6, 1};
        vecs[10] = '{"commit_tag_mismatch", 1, 0, 0, 0, 1, 7, 5, 32'h43,   7, 32'h43,   6, 1};
        vecs[11] = '{"commit_tag_match",    1, 0, 0, 0, 1, 7, 6, 32'h44,   7, 32'h44,   0, 0};
        vecs[12] = '{"commit_not_busy",     1, 0, 0, 0, 1, 7, 6, 32'h45,   7, 32'h45,   0, 0};

        // Reset state
        tick(); tick();
        rst = 0;
        #1;
        for (int r = 0; r < REG_NUM; r += 7) begin
            set_rd(0, r); set_rd(1, REG_NUM - 1 - r);
            #1;
            check($sformatf("reset_p0_r%0d", r), port_out(0), '0);
            check($sformatf("reset_p1_r%0d", REG_NUM - 1 - r), port_out(1), '0);
        end
        check("reset_ckpt_id", 64'(out_ckpt_id), 0);
        check("reset_ckpt_full", 64'(out_ckpt_full), 0);

        // Table-driven single-cycle operations
        for (int i = 0; i < 13; i++) begin
            idle();
            ena = vecs[i].en;
            in_assign_ena = vecs[i].a_en; in_assign_reg = vecs[i].a_reg; in_assign_tag = vecs[i].a_tag;
            in_commit_ena = vecs[i].c_en; in_commit_reg = vecs[i].c_reg;
            in_commit_tag = vecs[i].c_tag; in_commit_value = vecs[i].c_val;
            tick();
            idle();
            read_check(vecs[i].name, int'(vecs[i].chk), pack(vecs[i].e_val, vecs[i].e_tag, vecs[i].e_busy));
        end

        // Checkpoint restore with a retire in between
        do_reset();
        do_assign(2, 1);
        in_ckpt_save = 1; tick(); idle();
        check("save_advances_id", 64'(out_ckpt_id), 1);
        do_assign(2, 4);
        in_commit_ena = 1; in_commit_reg = 2; in_commit_tag = 1; in_commit_value = 32'h10;
        tick(); idle();
        read_check("commit_old_tag_live", 2, pack(32'h10, 4, 1));
        in_ckpt_restore = 1; in_ckpt_restore_id = 0;
        tick(); idle();
        read_check("restore_r2", 2, pack(32'h10, 0, 0));
        check("restore_frees_slot", {out_ckpt_full, 7'd0, 6'd0, out_ckpt_id}, 0);

        // Fill all slots, overflow save, release
        do_reset();
        for (int i = 0; i < CKPT_NUM; i++) begin
            check($sformatf("fill_id_%0d", i), {63'd0, out_ckpt_full} << 8 | 64'(out_ckpt_id), 64'(i));
            in_ckpt_save = 1; tick(); idle();
        end
        check("full_after_four", 64'(out_ckpt_full), 1);
        in_ckpt_save = 1; tick(); idle();
        check("fifth_save_ignored", 64'(out_ckpt_full), 1);
        in_ckpt_release = 1; in_ckpt_release_id = 2; in_ckpt_save = 1;
        tick(); idle();
        check("release2_id", 64'(out_ckpt_id), 2);
        check("release2_not_full", 64'(out_ckpt_full), 0);

        // Rollback with a same-cycle commit
        do_reset();
        for (int r = 1; r < REG_NUM; r++) begin
            idle(); in_assign_ena = 1; in_assign_reg = REG_W'(r); in_assign_tag = ROB_W'(r % 15 + 1);
            in_ckpt_save = (r == 10 || r == 20);
            tick();
        end
        idle();
        read_check("busy_before_rollback", 31, pack(0, 2, 1));
        in_rollback = 1; in_commit_ena = 1; in_commit_reg = 4; in_commit_tag = 0; in_commit_value = 32'hAA;
        tick(); idle();
        begin
            int busy_cnt;
            int tag_sum;
            busy_cnt = 0; tag_sum = 0;
            for (int r = 0; r < REG_NUM; r++) begin
                set_rd(1, r);
                #1;
                busy_cnt += int'(rd_busy[1]);
                tag_sum  += int'(rd_tag[ROB_W +: ROB_W]);
            end
            check("rollback_busy_count", 64'(busy_cnt), 0);
            check("rollback_tag_sum", 64'(tag_sum), 0);
        end
        read_check("rollback_r4_data", 4, pack(32'hAA, 0, 0));
        check("rollback_slots_free", {out_ckpt_full, 7'd0, 6'd0, out_ckpt_id}, 0);

        // Read during commit of the same register
        do_reset();
        do_assign(6, 2);
        in_commit_ena = 1; in_commit_reg = 6; in_commit_tag = 2; in_commit_value = 32'h55;
        set_rd(0, 6);
        #1;
`ifdef RENAME_RF_BYPASS_EN
        check("same_cycle_read_r6", port_out(0), pack(32'h55, 0, 0));
`else
        check("same_cycle_read_r6", port_out(0), pack(32'h0, 2, 1));
`endif
        tick(); idle();
        read_check("next_cycle_read_r6", 6, pack(32'h55, 0, 0));

        // Randomized run against the reference model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            ena = ($urandom_range(0, 9) != 0);
            in_rollback = ($urandom_range(0, 79) == 0);
            in_assign_ena = $urandom_range(0, 1);
            in_assign_reg = REG_W'($urandom_range(0, REG_NUM - 1));
            in_assign_tag = ROB_W'($urandom_range(1, 15));
            in_commit_ena = $urandom_range(0, 1);
            in_commit_reg = REG_W'($urandom_range(0, REG_NUM - 1));
            in_commit_tag = ($urandom_range(0, 9) < 7) ? m_tag[in_commit_reg] : ROB_W'($urandom);
            in_commit_value = $urandom;
            in_ckpt_save = ($urandom_range(0, 4) == 0);
            in_ckpt_restore = ($urandom_range(0, 9) == 0);
            in_ckpt_restore_id = CKPT_W'($urandom);
            in_ckpt_release = ($urandom_range(0, 6) == 0);
            in_ckpt_release_id = CKPT_W'($urandom);
            set_rd(0, $urandom_range(0, REG_NUM - 1));
            // Port 1 often reads the register being committed to exercise forwarding.
            set_rd(1, ($urandom_range(0, 1) == 1) ? int'(in_commit_reg) : $urandom_range(0, REG_NUM - 1));
            #1;
            check($sformatf("rand%0d_p0", cyc), port_out(0), model_read(int'(rd_idx[0 +: REG_W])));
            check($sformatf("rand%0d_p1", cyc), port_out(1), model_read(int'(rd_idx[REG_W +: REG_W])));
            begin
                int fs;
                fs = model_free_slot();
                check($sformatf("rand%0d_full", cyc), 64'(out_ckpt_full), 64'(fs < 0));
                if (fs >= 0) check($sformatf("rand%0d_id", cyc), 64'(out_ckpt_id), 64'(fs));
            end
            tick();
        end
        rst = 0;

        // Reset in the middle of activity discards everything
        idle();
        in_assign_ena = 1; in_assign_reg = 9; in_assign_tag = 3;
        in_commit_ena = 1; in_commit_reg = 11; in_commit_value = 32'hDEAD;
        in_ckpt_save = 1;
        rst = 1;
        tick();
        rst = 0; idle();
        begin
            int nonzero;
            nonzero = 0;
            for (int r = 0; r < REG_NUM; r++) begin
                set_rd(0, r);
                #1;
                if (port_out(0) != 0) nonzero++;
            end
            check("midop_reset_regs_nonzero", 64'(nonzero), 0);
        end
        check("midop_reset_ckpt", {out_ckpt_full, 7'd0, 6'd0, out_ckpt_id}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
